// File: rtl/net_ring_router_q_pkg.sv
// net_ring_router_q_pkg: shared net message layout helpers and route-direction encoding.
// Message layout is {dest, src, opaque, payload} with dest in the MSBs.
// route_dir() maps a destination id to the output port of a given router.
package net_ring_router_q_pkg;

  // Output port encoding, matching router port numbering.
  typedef enum logic [1:0] {
    OUT_PREV = 2'd0,
    OUT_TERM = 2'd1,
    OUT_NEXT = 2'd2
  } route_dir_e;

  function automatic int msg_nbits(input int p, input int o, input int s);
    return p + o + 2 * s;
  endfunction

  // fwd is the hop count going forward (towards id+1) around the ring.
  // Greedy mode takes the shorter way; an exact half-ring tie goes forward.
  function automatic route_dir_e route_dir(input int dest, input int id,
                                           input int n, input int mode);
    int fwd;
    fwd = (dest >= id) ? dest - id : dest + n - id;
    if (fwd == 0) return OUT_TERM;
    if (mode != 0) return OUT_NEXT;
    if (fwd <= n / 2) return OUT_NEXT;
    return OUT_PREV;
  endfunction

endpackage

// File: rtl/net_normal_queue.sv
// net_normal_queue: plain FIFO of DEPTH entries, no bypass.
// Latency: an entry written at edge t is visible at the head after edge t.
// Backpressure: enq_rdy = !full, combinational from the count only.
module net_normal_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_val,
  output logic             enq_rdy,
  input  logic [WIDTH-1:0] enq_msg,
  output logic             deq_val,
  input  logic             deq_rdy,
  output logic [WIDTH-1:0] deq_msg
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_enq, do_deq;

  assign enq_rdy = (count != CW'(DEPTH));
  assign deq_val = (count != '0);
  assign deq_msg = mem[rd_ptr];
  assign do_enq  = enq_val && enq_rdy;
  assign do_deq  = deq_val && deq_rdy;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= bump(wr_ptr);
      if (do_deq) rd_ptr <= bump(rd_ptr);
      if (do_enq && !do_deq)      count <= count + CW'(1);
      else if (do_deq && !do_enq) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_msg;
  end

endmodule

// File: rtl/net_rr_arb3.sv
// net_rr_arb3: 3-requester round-robin arbiter, pointer advances only on a transfer.
// Latency: grant is combinational from requests and registered pointer/lock state.
// Backpressure: while a grant is outstanding without a transfer it is locked, so the winner holds.
module net_rr_arb3 (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       en,     // granted message transferred this cycle
  output logic [2:0] grant
);
  logic [1:0] ptr;
  logic       locked;
  logic [2:0] held;
  logic [2:0] pick;

  always_comb begin
    pick = 3'b000;
    case (ptr)
      2'd1:    pick = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
      2'd2:    pick = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
      default: pick = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
    endcase
    // A higher-priority head arriving during a stall must not steal the output.
    grant = locked ? held : pick;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr    <= 2'd0;
      locked <= 1'b0;
      held   <= 3'b000;
    end else if (en) begin
      locked <= 1'b0;
      ptr    <= grant[0] ? 2'd1 : (grant[1] ? 2'd2 : 2'd0);
    end else if (|grant) begin
      locked <= 1'b1;
      held   <= grant;
    end
  end

endmodule

// File: rtl/net_ring_router_q.sv
// net_ring_router_q: 3-port ring router with per-port input queues and round-robin output arbitration.
// Latency: a message accepted at edge t can leave at edge t+1 at the earliest.
// Backpressure: in*_rdy drops when that queue is full; a stalled output holds its grant and message.
// Ports: in0/out0 face router id-1, in1/out1 the terminal, in2/out2 router id+1;
//        each channel is val/rdy/msg with msg = {dest, src, opaque, payload}.
module net_ring_router_q
  import net_ring_router_q_pkg::*;
#(
  parameter int p_payload_nbits = 8,
  parameter int p_opaque_nbits  = 8,
  parameter int p_srcdest_nbits = 3,
  parameter int p_router_id     = 0,
  parameter int p_num_routers   = 8,
  parameter int p_num_entries   = 2,
  parameter int p_route_mode    = 0,
  localparam int M = msg_nbits(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in0_val,
  output logic         in0_rdy,
  input  logic [M-1:0] in0_msg,
  input  logic         in1_val,
  output logic         in1_rdy,
  input  logic [M-1:0] in1_msg,
  input  logic         in2_val,
  output logic         in2_rdy,
  input  logic [M-1:0] in2_msg,
  output logic         out0_val,
  input  logic         out0_rdy,
  output logic [M-1:0] out0_msg,
  output logic         out1_val,
  input  logic         out1_rdy,
  output logic [M-1:0] out1_msg,
  output logic         out2_val,
  input  logic         out2_rdy,
  output logic [M-1:0] out2_msg
);
  logic [2:0]   q_val, q_rdy, head_val, head_rdy;
  logic [M-1:0] q_msg    [3];
  logic [M-1:0] head_msg [3];
  route_dir_e   head_dir [3];
  logic [2:0]   req      [3];   // req[out][queue]
  logic [2:0]   grant    [3];   // grant[out][queue]
  logic [2:0]   o_val, o_rdy, o_xfer;
  logic [M-1:0] o_msg    [3];

  assign q_val    = {in2_val, in1_val, in0_val};
  assign q_msg[0] = in0_msg;
  assign q_msg[1] = in1_msg;
  assign q_msg[2] = in2_msg;
  assign in0_rdy  = q_rdy[0];
  assign in1_rdy  = q_rdy[1];
  assign in2_rdy  = q_rdy[2];

  for (genvar i = 0; i < 3; i++) begin : g_port
    net_normal_queue #(.WIDTH(M), .DEPTH(p_num_entries)) u_queue (
      .clk     (clk),
      .reset   (reset),
      .enq_val (q_val[i]),
      .enq_rdy (q_rdy[i]),
      .enq_msg (q_msg[i]),
      .deq_val (head_val[i]),
      .deq_rdy (head_rdy[i]),
      .deq_msg (head_msg[i])
    );
    assign head_dir[i] = route_dir(int'(head_msg[i][M-1 -: p_srcdest_nbits]),
                                   p_router_id, p_num_routers, p_route_mode);
  end

  // Each head requests exactly one output, so a blocked head never blocks another queue.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        req[k][i] = head_val[i] && (head_dir[i] == 2'(k));
      end
    end
  end

  always_comb begin
    head_rdy = 3'b000;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) begin
        head_rdy[i] = head_rdy[i] | (grant[k][i] & o_rdy[k]);
      end
    end
  end

  assign o_rdy = {out2_rdy, out1_rdy, out0_rdy};

  for (genvar k = 0; k < 3; k++) begin : g_out
    net_rr_arb3 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req[k]),
      .en    (o_xfer[k]),
      .grant (grant[k])
    );
    assign o_val[k]  = |grant[k];
    assign o_xfer[k] = o_val[k] && o_rdy[k];
    assign o_msg[k]  = grant[k][2] ? head_msg[2] :
                       grant[k][1] ? head_msg[1] : head_msg[0];
  end

  assign out0_val = o_val[0];
  assign out1_val = o_val[1];
  assign out2_val = o_val[2];
  assign out0_msg = o_msg[0];
  assign out1_msg = o_msg[1];
  assign out2_msg = o_msg[2];

endmodule

// File: tb/tb_net_ring_router_q.sv
`timescale 1ns/1ps
module tb_net_ring_router_q;
  localparam int P  = 8;
  localparam int O  = 8;
  localparam int S  = 3;
  localparam int N  = 8;
  localparam int M  = P + O + 2 * S;
  localparam int NI = 4;   // instances: 0 id2/greedy, 1 id2/forward, 2 id7/greedy, 3 id0/greedy

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         in_val  [NI][3];
  logic         in_rdy  [NI][3];
  logic [M-1:0] in_msg  [NI][3];
  logic         out_val [NI][3];
  logic         out_rdy [NI][3];
  logic [M-1:0] out_msg [NI][3];

  int n_chk  = 0;
  int n_fail = 0;

  logic [M-1:0] txq [3][$];
  int           exp_port [256];
  logic         seen     [256];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int ID   = (g == 2) ? 7 : (g == 3) ? 0 : 2;
    localparam int MODE = (g == 1) ? 1 : 0;
    net_ring_router_q #(
      .p_payload_nbits (P), .p_opaque_nbits (O), .p_srcdest_nbits (S),
      .p_router_id (ID), .p_num_routers (N), .p_num_entries (2), .p_route_mode (MODE)
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .in0_val  (in_val[g][0]),  .in0_rdy  (in_rdy[g][0]),  .in0_msg  (in_msg[g][0]),
      .in1_val  (in_val[g][1]),  .in1_rdy  (in_rdy[g][1]),  .in1_msg  (in_msg[g][1]),
      .in2_val  (in_val[g][2]),  .in2_rdy  (in_rdy[g][2]),  .in2_msg  (in_msg[g][2]),
      .out0_val (out_val[g][0]), .out0_rdy (out_rdy[g][0]), .out0_msg (out_msg[g][0]),
      .out1_val (out_val[g][1]), .out1_rdy (out_rdy[g][1]), .out1_msg (out_msg[g][1]),
      .out2_val (out_val[g][2]), .out2_rdy (out_rdy[g][2]), .out2_msg (out_msg[g][2])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [M-1:0] mk(input int d, input int s, input int o, input int p);
    assert (d < N) else $fatal(1, "illegal dest %0d in stimulus", d);
    return {3'(d), 3'(s), 8'(o), 8'(p)};
  endfunction

  // Reference route for router id 2, greedy: forward hops 1..4 go out2, 5..7 out0.
  function automatic int model_port(input int dest);
    int fwd;
    fwd = (dest + N - 2) % N;
    if (fwd == 0) return 1;
    return (fwd <= 4) ? 2 : 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int g = 0; g < NI; g++)
      for (int p = 0; p < 3; p++) begin
        in_val[g][p]  = 1'b0;
        out_rdy[g][p] = 1'b1;
      end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One message in; it must be on the expected port one cycle later, and gone the cycle after.
  task automatic route_test(input string tag, input int u, input int p,
                            input logic [M-1:0] m, input int port);
    @(negedge clk);
    check({tag, ".rdy"}, in_rdy[u][p], 1);
    in_val[u][p] = 1'b1;
    in_msg[u][p] = m;
    @(negedge clk);
    in_val[u][p] = 1'b0;
    for (int k = 0; k < 3; k++)
      check($sformatf("%s.val%0d", tag, k), out_val[u][k], (k == port));
    check({tag, ".msg"}, out_msg[u][port], m);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("%s.once%0d", tag, k), out_val[u][k], 0);
  endtask

  task automatic feed(input int u, input int p, input int maxdly);
    int guard;
    while (txq[p].size() > 0) begin
      @(negedge clk);
      in_val[u][p] = 1'b0;
      repeat ($urandom_range(0, maxdly)) @(negedge clk);
      in_val[u][p] = 1'b1;
      in_msg[u][p] = txq[p].pop_front();
      guard = 0;
      while (!in_rdy[u][p] && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        check($sformatf("feed%0d.timeout", p), guard, 0);
        txq[p].delete();
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_val[u][p] = 1'b0;
  endtask

  task automatic mon_contention();
    int k;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_val[0][1]) begin
        check($sformatf("cont.msg%0d", k), out_msg[0][1], mk(2, k % 3, 0, (k % 3) * 16 + k / 3));
        k++;
      end
      check("cont.stray", {out_val[0][0], out_val[0][2]}, 0);
    end
    check("cont.count", k, 12);
  endtask

  task automatic mon_rand();
    int got, cyc, id;
    got = 0;
    cyc = 0;
    while (got < 50 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 3; k++) out_rdy[0][k] = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 3; k++) begin
        if (out_val[0][k] && out_rdy[0][k]) begin
          id = int'(out_msg[0][k][7:0]);
          check($sformatf("rand.port.id%0d", id), k, exp_port[id]);
          check($sformatf("rand.dup.id%0d", id), seen[id], 0);
          seen[id] = 1'b1;
          got++;
        end
      end
    end
    check("rand.count", got, 50);
    check("rand.in_time", (cyc < 500), 1);
    for (int k = 0; k < 3; k++) out_rdy[0][k] = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [M-1:0] a, b, c, d, e, f;
    logic [M-1:0] exp_q [4];
    logic [M-1:0] got [$];
    logic         acc;
    a = mk(3, 2, 1, 'ha0);
    b = mk(3, 2, 1, 'hb0);
    c = mk(3, 2, 1, 'hc0);
    d = mk(3, 4, 2, 'hd0);
    e = mk(3, 2, 0, 'he0);
    f = mk(3, 2, 0, 'hf0);
    do_reset();
    out_rdy[0][2] = 1'b0;
    @(negedge clk); in_val[0][1] = 1'b1; in_msg[0][1] = a;
    @(negedge clk); in_msg[0][1] = b;
    @(negedge clk); in_msg[0][1] = c;
    check("bp.full", in_rdy[0][1], 0);
    check("bp.val", out_val[0][2], 1);
    check("bp.head", out_msg[0][2], a);
    // in0 outranks in1 at pointer 0; the stalled grant must still stay on a.
    in_val[0][0] = 1'b1;
    in_msg[0][0] = d;
    @(negedge clk);
    in_val[0][0] = 1'b0;
    check("bp.still_full", in_rdy[0][1], 0);
    check("bp.stable1", out_msg[0][2], a);
    repeat (3) @(negedge clk);
    check("bp.stable2", out_msg[0][2], a);
    check("bp.val2", out_val[0][2], 1);
    out_rdy[0][2] = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_val[0][2]) got.push_back(out_msg[0][2]);
      acc = in_val[0][1] && in_rdy[0][1];
      @(negedge clk);
      if (acc) in_val[0][1] = 1'b0;
    end
    // After a, pointer is 2 so in0's d wins before in1's b; then b, then c.
    exp_q[0] = a; exp_q[1] = d; exp_q[2] = b; exp_q[3] = c;
    check("bp.count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      check($sformatf("bp.order%0d", i), got[i], exp_q[i]);

    out_rdy[0][2] = 1'b0;
    @(negedge clk); in_val[0][1] = 1'b1; in_msg[0][1] = e;
    @(negedge clk); in_msg[0][1] = f;
    @(negedge clk); in_val[0][1] = 1'b0;
    check("rst.pre", out_val[0][2], 1);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst.val%0d", k), out_val[0][k], 0);
      check($sformatf("rst.rdy%0d", k), in_rdy[0][k], 1);
    end
    @(negedge clk);
    reset = 1'b0;
    out_rdy[0][2] = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.flushed", out_val[0][2], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int g = 0; g < NI; g++)
      for (int p = 0; p < 3; p++) begin
        in_val[g][p]  = 1'b0;
        in_msg[g][p]  = '0;
        out_rdy[g][p] = 1'b1;
      end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset.out_val%0d", k), out_val[0][k], 0);
      check($sformatf("reset.in_rdy%0d", k), in_rdy[0][k], 1);
    end
    reset = 1'b0;

    route_test("self",    0, 1, mk(2, 2, 0, 'hce), 1);
    route_test("g.d4",    0, 1, mk(4, 2, 1, 'h11), 2);
    route_test("g.d1",    0, 1, mk(1, 2, 2, 'h22), 0);
    route_test("g.tie",   0, 0, mk(6, 4, 3, 'h33), 2);
    route_test("g.d7",    0, 2, mk(7, 3, 4, 'h44), 0);
    route_test("g.d5",    0, 1, mk(5, 2, 5, 'h55), 2);
    route_test("m1.d1",   1, 1, mk(1, 2, 6, 'h66), 2);
    route_test("m1.d2",   1, 0, mk(2, 1, 7, 'h77), 1);
    route_test("m1.d7",   1, 1, mk(7, 2, 0, 'h88), 2);
    route_test("w7.d0",   2, 1, mk(0, 7, 1, 'h99), 2);
    route_test("w7.d4",   2, 1, mk(4, 7, 2, 'haa), 0);
    route_test("w7.d7",   2, 2, mk(7, 0, 3, 'hbb), 1);
    route_test("w0.d7",   3, 1, mk(7, 0, 4, 'hcc), 0);
    route_test("w0.in0",  3, 0, mk(0, 7, 5, 'hdd), 1);
    route_test("w0.tie",  3, 1, mk(4, 0, 6, 'hee), 2);

    do_reset();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 4; i++) txq[p].push_back(mk(2, p, 0, p * 16 + i));
    fork
      feed(0, 0, 0);
      feed(0, 1, 0);
      feed(0, 2, 0);
      mon_contention();
    join

    test_backpressure();

    do_reset();
    for (int id = 0; id < 50; id++) begin
      int dest;
      dest = $urandom_range(0, N - 1);
      exp_port[id] = model_port(dest);
      seen[id] = 1'b0;
      txq[id % 3].push_back(mk(dest, $urandom_range(0, N - 1), id % 3, id));
    end
    fork
      feed(0, 0, 3);
      feed(0, 1, 3);
      feed(0, 2, 3);
      mon_rand();
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
